// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode.
// Holds {PC, instruction} pairs captured from fetch and presents the oldest
// one to decode under a valid/ready handshake. A flush drops every queued
// entry on a redirect. Entries become visible one cycle after capture; there
// is no bypass from fetch to decode.
module fetch_queue #(
    parameter int N     = 64,
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid_F,
    input  logic [N-1:0]               pc_F,
    input  logic [W-1:0]               instr_F,
    output logic                       enq_ready_F,
    output logic                       deq_valid_D,
    input  logic                       deq_ready_D,
    output logic [N-1:0]               pc_D,
    output logic [W-1:0]               instr_D,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Decode sees a LEGv8 NOP whenever the queue has nothing to offer.
    localparam logic [W-1:0] NOP_INSTR = W'(32'hD503201F);

    // Storage is deliberately left unreset; only the pointers and count matter.
    logic [N-1:0]  pc_mem_r    [DEPTH];
    logic [W-1:0]  instr_mem_r [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          enq_fire_s;
    logic          deq_fire_s;
    logic          not_empty_s;

    // Handshake status derived only from the registered occupancy, so ready
    // never depends combinationally on the decode side.
    always_comb begin
        not_empty_s = (count_r != {CW{1'b0}});
        enq_ready_F = (count_r < CW'(DEPTH));
        deq_valid_D = not_empty_s;
        enq_fire_s  = enq_valid_F && enq_ready_F;
        deq_fire_s  = not_empty_s && deq_ready_D;
        count       = count_r;
    end

    // Head-entry presentation; empty queue shows PC 0 and a NOP.
    always_comb begin
        if (not_empty_s) begin
            pc_D    = pc_mem_r[rd_ptr_r];
            instr_D = instr_mem_r[rd_ptr_r];
        end else begin
            pc_D    = {N{1'b0}};
            instr_D = NOP_INSTR;
        end
    end

    // Capture the offered entry into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (enq_fire_s && !flush) begin
            pc_mem_r[wr_ptr_r]    <= pc_F;
            instr_mem_r[wr_ptr_r] <= instr_F;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks both handshakes,
    // and pointers wrap by natural binary overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver pushes every entry it expects
// the queue to accept; a negedge monitor pops and compares on each dequeue.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid_F;
    logic [63:0] pc_F;
    logic [31:0] instr_F;
    logic        enq_ready_F;
    logic        deq_valid_D;
    logic        deq_ready_D;
    logic [63:0] pc_D;
    logic [31:0] instr_D;
    logic        flush;
    logic [2:0]  count;

    int tests_run = 0;
    int failures  = 0;
    int model_cnt = 0;
    logic [95:0] sb [$];

    fetch_queue #(.N(64), .W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .enq_valid_F(enq_valid_F), .pc_F(pc_F), .instr_F(instr_F),
        .enq_ready_F(enq_ready_F),
        .deq_valid_D(deq_valid_D), .deq_ready_D(deq_ready_D),
        .pc_D(pc_D), .instr_D(instr_D),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen mid-cycle will fire on the next edge.
    always @(negedge clk) begin
        if (!reset && !flush && deq_valid_D && deq_ready_D) begin
            tests_run++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL deq_unexpected: got pc %0h instr %0h, expected no entry", pc_D, instr_D);
            end else begin
                logic [95:0] exp;
                exp = sb.pop_front();
                if ({pc_D, instr_D} !== exp) begin
                    failures++;
                    $display("FAIL deq_order: got pc %0h instr %0h, expected pc %0h instr %0h",
                             pc_D, instr_D, exp[95:32], exp[31:0]);
                end
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_count"}, 64'(count), 64'(model_cnt));
        check({tag, "_deq_valid"}, 64'(deq_valid_D), 64'(model_cnt != 0));
        check({tag, "_enq_ready"}, 64'(enq_ready_F), 64'(model_cnt < 4));
    endtask

    // One cycle of stimulus starting just after a rising edge.
    task automatic step(input logic e, input logic [63:0] p, input logic [31:0] ins,
                        input logic d, input logic f, input string tag, output logic acc);
        logic dfire;
        enq_valid_F = e; pc_F = p; instr_F = ins; deq_ready_D = d; flush = f;
        acc   = e && (model_cnt < 4);
        dfire = d && (model_cnt > 0);
        if (acc && !f) sb.push_back({p, ins});
        @(posedge clk); #1;
        if (f) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            model_cnt = model_cnt + int'(acc) - int'(dfire);
        end
        enq_valid_F = 1'b0; deq_ready_D = 1'b0; flush = 1'b0;
        check_status(tag);
    endtask

    task automatic enq(input logic [63:0] p, input logic [31:0] ins, input string tag);
        logic acc;
        step(1'b1, p, ins, 1'b0, 1'b0, tag, acc);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int guard = 0;
        while (model_cnt > 0 && guard < 20) begin
            step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, tag, acc);
            guard++;
        end
        check({tag, "_empty_valid"}, 64'(deq_valid_D), 64'h0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 64'(count), 64'h0);
        check({tag, "_deq_valid"}, 64'(deq_valid_D), 64'h0);
        check({tag, "_enq_ready"}, 64'(enq_ready_F), 64'h1);
        check({tag, "_pc"}, pc_D, 64'h0);
        check({tag, "_instr"}, 64'(instr_D), 64'(NOP));
    endtask

    initial begin
        logic acc;
        int sent;
        int cyc;
        logic [63:0] p;

        enq_valid_F = 1'b0; pc_F = 64'h0; instr_F = 32'h0;
        deq_ready_D = 1'b0; flush = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_init");
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Fill to DEPTH, offer a fifth entry, then drain in order.
        enq(64'h0, 32'h8B020020, "fill0");
        enq(64'h4, 32'hCB020020, "fill1");
        enq(64'h8, 32'hF8000020, "fill2");
        enq(64'hC, 32'hB4000040, "fill3");
        check("fill_count4", 64'(count), 64'h4);
        check("fill_full_ready", 64'(enq_ready_F), 64'h0);
        step(1'b1, 64'h10, 32'h91000000, 1'b0, 1'b0, "fill_drop", acc);
        check("fill_drop_acc", 64'(acc), 64'h0);
        check("head_pc", pc_D, 64'h0);
        // Dequeue while full, with a refused offer in the same cycle.
        step(1'b1, 64'h10, 32'h91000000, 1'b1, 1'b0, "full_deq", acc);
        check("full_deq_count", 64'(count), 64'h3);
        drain("fill_drain");
        check("empty_pc", pc_D, 64'h0);
        check("empty_instr", 64'(instr_D), 64'(NOP));

        // Simultaneous enqueue and dequeue at count 2.
        enq(64'h14, 32'hAA000014, "sim0");
        enq(64'h18, 32'hAA000018, "sim1");
        step(1'b1, 64'h20, 32'hAA000020, 1'b1, 1'b0, "sim_both", acc);
        check("sim_count", 64'(count), 64'h2);
        check("sim_head", pc_D, 64'h18);
        drain("sim_drain");

        // Empty queue ignores deq_ready_D.
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "empty_deq", acc);

        // Flush at count 3 together with enqueue and dequeue.
        enq(64'h30, 32'hBB000030, "fl0");
        enq(64'h34, 32'hBB000034, "fl1");
        enq(64'h38, 32'hBB000038, "fl2");
        step(1'b1, 64'h40, 32'hBB000040, 1'b1, 1'b1, "flush", acc);
        check("flush_count", 64'(count), 64'h0);
        check("flush_pc", pc_D, 64'h0);
        enq(64'h44, 32'hBB000044, "post_flush");
        drain("flush_drain");

        // Wrap-around stream with decode ready every other cycle.
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 100) begin
            p = 64'(sent * 4);
            step(1'b1, p, 32'hCC000000 | 32'(sent), 1'(cyc % 2), 1'b0, "wrap", acc);
            check("wrap_max", 64'(count <= 3'd4), 64'h1);
            if (acc) sent++;
            cyc++;
        end
        check("wrap_sent", 64'(sent), 64'd10);
        drain("wrap_drain");

        // Asynchronous reset mid-operation at count 3.
        enq(64'h50, 32'hDD000050, "rst0");
        enq(64'h54, 32'hDD000054, "rst1");
        enq(64'h58, 32'hDD000058, "rst2");
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_mid");
        sb.delete();
        model_cnt = 0;
        #4 reset = 1'b0;
        @(posedge clk); #1;
        enq(64'h100, 32'hEE000100, "after_rst");
        check("after_rst_pc", pc_D, 64'h100);
        drain("after_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
